pattern_stage: RTL and testbench
================================

Name: pattern_stage

Overview:
- Sequence source and presenter for the memory game. It generates a growing random sequence of 2-bit symbols and shows it to the player.
- During the player's turn it drives the expected symbol onto `data` for compareStage, then consumes compareStage's `t`/`f` verdict.
- It is the producer/checker-driver counterpart of compareStage: compareStage judges one press; this block decides what is judged and advances the round.

Parameters:
- DEPTH, 8: maximum sequence length; reaching it wins the game (2..16).
- ON_CYC, 4: clock cycles each symbol is lit during the show phase (>=1).
- OFF_CYC, 2: dark cycles between shown symbols (>=1).
- SEED, 8'hA5: LFSR reset seed; must be nonzero.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a new game from IDLE, WIN or LOSE.
- buttonOn  in  1  player press level; same signal that feeds compareStage.
- t  in  1  compareStage "match" verdict.
- f  in  1  compareStage "mismatch" verdict.
- data  out  2  expected symbol presented to compareStage.
- show  out  2  symbol currently displayed to the player.
- showValid  out  1  high while `show` is lit.
- inputPhase  out  1  high while the player's presses are being accepted.
- level  out  5  current sequence length L (0 in IDLE).
- win  out  1  level-high in WIN.
- lose  out  1  level-high in LOSE.

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE, LFSR=SEED, L=0, idx=0, timer=0, symbol memory cleared to 0.
  - All outputs 0.
  - Reset has priority over every other input in any state, including mid-show and mid-input.
- LFSR:
  - 8-bit, shifts left once per GEN.
  - New bit0 = x7^x5^x4^x3.
  - New symbol = updated LFSR[1:0], written to mem[L] before L increments.
- States:
  - IDLE: on start -> GEN.
  - GEN: one cycle. Store symbol, L<=L+1, idx<=0 -> SHOW_ON.
  - SHOW_ON:
    - show=mem[idx], showValid=1 for exactly ON_CYC cycles, then -> SHOW_OFF.
  - SHOW_OFF:
    - show=0, showValid=0 for OFF_CYC cycles.
    - Then if idx==L-1: idx<=0 and -> WAIT_IN; else idx<=idx+1 and -> SHOW_ON.
  - WAIT_IN:
    - inputPhase=1, data=mem[idx].
    - Rising edge of buttonOn (registered prev-value detect) -> CHECK. A held button does not retrigger.
  - CHECK: one cycle, samples t/f.
    - t=1, f=0, idx<L-1: idx++ -> WAIT_IN.
    - t=1, f=0, idx==L-1: if L==DEPTH -> WIN, else -> GEN.
    - Any other combination (f=1, neither, or both) -> LOSE.
  - WIN / LOSE: sticky. start -> clear L, idx and memory -> GEN. The LFSR is not reseeded.
- data:
  - Holds mem[idx] in WAIT_IN and CHECK.
  - 2'b00 in all other states.
- Button activity outside WAIT_IN is ignored, including in SHOW_ON/SHOW_OFF. The edge detector still tracks buttonOn so that a press held across entry to WAIT_IN does not count.
- start outside IDLE/WIN/LOSE is ignored.
- Timing:
  - All outputs are registered: one-cycle latency from state entry.
  - Show phase of a round lasts L*(ON_CYC+OFF_CYC) cycles.
- Widths: level is zero-extended L; idx is clog2(DEPTH) bits. No wrap-around is possible because L never exceeds DEPTH.

Optional Feature:
- PATTERN_STAGE_FREESEED_EN.
  - Defined: an 8-bit free-running counter increments every cycle from reset. On a start accepted in IDLE, the LFSR loads counter value (forced to 8'h01 if zero) instead of keeping SEED.
  - Undefined: the LFSR is seeded only from SEED at reset, giving a fully deterministic sequence.

Decomposition:
- Shared package pattern_pkg:
  - State enum (IDLE, GEN, SHOW_ON, SHOW_OFF, WAIT_IN, CHECK, WIN, LOSE).
  - LFSR tap constant.
  - Symbol width constant (2).
- Sub-module pattern_lfsr: 8-bit Fibonacci LFSR with load, step and seed inputs. Reused later by other game stages.

Test Plan:
- Reset, then start. GEN stores mem[0]=2'b10 (LFSR 8'hA5->8'h4A); level=1. showValid high ON_CYC cycles with show=2'b10, then WAIT_IN with data=2'b10.
- Round 1: press with t=1,f=0 -> GEN, level=2. Show phase replays 2 symbols, mem[0] unchanged at 2'b10.
- Round 2: first press t=1, second press f=1 -> lose=1, inputPhase=0, data=00. A later start -> level=1.
- Hold buttonOn high from SHOW_ON into WAIT_IN: no CHECK until buttonOn falls and rises again. Also apply t=0,f=0 in CHECK -> LOSE.
- DEPTH=4: answer all rounds correctly -> win=1 after the 4th CHECK, level=4. start pulses in SHOW_ON are ignored.
- Assert reset mid-SHOW_ON with L=3 -> next cycle all outputs 0, level=0, state IDLE. With PATTERN_STAGE_FREESEED_EN, two starts at different cycle counts give different first symbols.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared types and constants for the memory-game pattern stages.
package pattern_pkg;

  localparam int symWidth = 2;

  // Feedback taps x7, x5, x4, x3
  localparam logic [7:0] lfsrTaps = 8'hB8;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    SHOW_ON,
    SHOW_OFF,
    WAIT_IN,
    CHECK,
    WIN,
    LOSE
  } stateT;

endpackage

// File: rtl/pattern_lfsr.sv
// 8-bit Fibonacci LFSR with parallel load and single-step advance.
module pattern_lfsr
  import pattern_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] value,
  output logic [7:0] nextValue
);

  assign nextValue = {value[6:0], ^(value & lfsrTaps)};

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= SEED;
    end else if (load) begin
      value <= seed;
    end else if (step) begin
      value <= nextValue;
    end
  end

endmodule

// File: rtl/pattern_stage.sv
// Memory-game sequence generator/presenter; drives the expected symbol to compareStage.
// Optional: PATTERN_STAGE_FREESEED_EN seeds the LFSR from a free-running counter at start.
module pattern_stage
  import pattern_pkg::*;
#(
  parameter int         DEPTH   = 8,
  parameter int         ON_CYC  = 4,
  parameter int         OFF_CYC = 2,
  parameter logic [7:0] SEED    = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       buttonOn,
  input  logic       t,
  input  logic       f,
  output logic [1:0] data,
  output logic [1:0] show,
  output logic       showValid,
  output logic       inputPhase,
  output logic [4:0] level,
  output logic       win,
  output logic       lose
);

  localparam int IW = $clog2(DEPTH);

  stateT state, nextState;

  logic [4:0]          len;
  logic [IW-1:0]       idx;
  logic [15:0]         timer;
  logic [symWidth-1:0] mem [DEPTH];
  logic                prevBtn;

  logic btnRise, lastIdx, onDone, offDone, pass, startOk;
  logic lfsrLoad;
  logic [7:0] lfsrSeed, lfsrValue, lfsrNext;
  logic unusedLfsrBits;

  assign btnRise = buttonOn & ~prevBtn;
  assign lastIdx = (5'(idx) == len - 5'd1);
  assign onDone  = (timer == 16'(ON_CYC - 1));
  assign offDone = (timer == 16'(OFF_CYC - 1));
  assign pass    = t & ~f;
  assign startOk = start & ((state == IDLE) | (state == WIN) | (state == LOSE));
  assign level   = len;

`ifdef PATTERN_STAGE_FREESEED_EN
  logic [7:0] freeCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      freeCnt <= '0;
    end else begin
      freeCnt <= freeCnt + 8'd1;
    end
  end

  // Zero would lock the LFSR, so a zero count seeds with 1 instead
  assign lfsrLoad = start & (state == IDLE);
  assign lfsrSeed = (freeCnt == 8'd0) ? 8'h01 : freeCnt;
`else
  assign lfsrLoad = 1'b0;
  assign lfsrSeed = '0;
`endif

  pattern_lfsr #(.SEED(SEED)) lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (lfsrLoad),
    .step     (state == GEN),
    .seed     (lfsrSeed),
    .value    (lfsrValue),
    .nextValue(lfsrNext)
  );

  assign unusedLfsrBits = ^{lfsrValue, lfsrNext[7:2]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (start) nextState = GEN;
      GEN:      nextState = SHOW_ON;
      SHOW_ON:  if (onDone) nextState = SHOW_OFF;
      SHOW_OFF: if (offDone) nextState = lastIdx ? WAIT_IN : SHOW_ON;
      WAIT_IN:  if (btnRise) nextState = CHECK;
      CHECK: begin
        if (!pass) begin
          nextState = LOSE;
        end else if (!lastIdx) begin
          nextState = WAIT_IN;
        end else begin
          nextState = (len == 5'(DEPTH)) ? WIN : GEN;
        end
      end
      WIN, LOSE: if (start) nextState = GEN;
      default:  nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len        <= '0;
      idx        <= '0;
      timer      <= '0;
      prevBtn    <= 1'b0;
      data       <= '0;
      show       <= '0;
      showValid  <= 1'b0;
      inputPhase <= 1'b0;
      win        <= 1'b0;
      lose       <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      prevBtn <= buttonOn;
      case (state)
        GEN: begin
          mem[len[IW-1:0]] <= lfsrNext[symWidth-1:0];
          len   <= len + 5'd1;
          idx   <= '0;
          timer <= '0;
        end
        SHOW_ON: timer <= onDone ? '0 : timer + 16'd1;
        SHOW_OFF: begin
          if (offDone) begin
            timer <= '0;
            idx   <= lastIdx ? '0 : idx + 1'b1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        CHECK: if (pass && !lastIdx) idx <= idx + 1'b1;
        default: begin
          if (startOk) begin
            len <= '0;
            idx <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
          end
        end
      endcase

      // Outputs decode the current state, so they follow state entry by one cycle
      showValid  <= (state == SHOW_ON);
      show       <= (state == SHOW_ON) ? mem[idx] : '0;
      data       <= ((state == WAIT_IN) || (state == CHECK)) ? mem[idx] : '0;
      inputPhase <= (state == WAIT_IN);
      win        <= (state == WIN);
      lose       <= (state == LOSE);
    end
  end

endmodule

// File: tb/tb_pattern_stage.sv
// Directed self-checking bench for pattern_stage (DEPTH=4, ON_CYC=4, OFF_CYC=2).
module tb_pattern_stage;

  localparam int ON  = 4;
  localparam int OFF = 2;

  logic       clk = 1'b0;
  logic       reset, start, buttonOn, t, f;
  logic [1:0] data, show;
  logic       showValid, inputPhase, win, lose;
  logic [4:0] level;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pattern_stage #(.DEPTH(4), .ON_CYC(ON), .OFF_CYC(OFF), .SEED(8'hA5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .buttonOn  (buttonOn),
    .t         (t),
    .f         (f),
    .data      (data),
    .show      (show),
    .showValid (showValid),
    .inputPhase(inputPhase),
    .level     (level),
    .win       (win),
    .lose      (lose)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".data"}, 8'(data), 8'h0);
    check({tag, ".show"}, 8'(show), 8'h0);
    check({tag, ".showValid"}, 8'(showValid), 8'h0);
    check({tag, ".inputPhase"}, 8'(inputPhase), 8'h0);
    check({tag, ".level"}, 8'(level), 8'h0);
    check({tag, ".win"}, 8'(win), 8'h0);
    check({tag, ".lose"}, 8'(lose), 8'h0);
  endtask

  task automatic startGame;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
  endtask

  task automatic press(input logic tv, input logic fv);
    buttonOn = 1'b1;
    t = tv;
    f = fv;
    tick;
    tick;
    buttonOn = 1'b0;
    t = 1'b0;
    f = 1'b0;
    tick;
  endtask

  task automatic waitShow;
    int n = 0;
    while (!showValid && n < 20) begin
      tick;
      n++;
    end
    check("showBegins", 8'(showValid), 8'h1);
  endtask

  // syms holds symbol i at bits [2i+1:2i]
  task automatic runShow(input int len, input logic [7:0] syms, input bit pulseStart);
    waitShow();
    for (int i = 0; i < len; i++) begin
      for (int c = 0; c < ON; c++) begin
        check($sformatf("on%0d.%0d.valid", i, c), 8'(showValid), 8'h1);
        check($sformatf("on%0d.%0d.show", i, c), 8'(show), 8'(syms[2*i +: 2]));
        if (pulseStart && i == 0 && c == 1) start = 1'b1;
        tick;
        start = 1'b0;
      end
      for (int c = 0; c < OFF; c++) begin
        check($sformatf("off%0d.%0d.valid", i, c), 8'(showValid), 8'h0);
        check($sformatf("off%0d.%0d.show", i, c), 8'(show), 8'h0);
        tick;
      end
    end
  endtask

  task automatic playRound(input int len, input logic [7:0] syms, input bit pulseStart);
    check($sformatf("round%0d.level", len), 8'(level), 8'(len));
    runShow(len, syms, pulseStart);
    for (int i = 0; i < len; i++) begin
      check($sformatf("round%0d.in%0d.phase", len, i), 8'(inputPhase), 8'h1);
      check($sformatf("round%0d.in%0d.data", len, i), 8'(data), 8'(syms[2*i +: 2]));
      press(1'b1, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    buttonOn = 1'b0;
    t = 1'b0;
    f = 1'b0;
    tick;
    tick;
    checkAllZero("reset");
    reset = 1'b0;

    // Game 1: A5->4A (10), 4A->95 (01)
    startGame();
    check("g1.level1", 8'(level), 8'h1);
    runShow(1, 8'b0000_0010, 1'b0);
    check("g1.r1.phase", 8'(inputPhase), 8'h1);
    check("g1.r1.data", 8'(data), 8'h2);
    press(1'b1, 1'b0);
    check("g1.level2", 8'(level), 8'h2);
    check("g1.genPhase", 8'(inputPhase), 8'h0);
    runShow(2, 8'b0000_0110, 1'b0);
    check("g1.r2.phase0", 8'(inputPhase), 8'h1);
    check("g1.r2.data0", 8'(data), 8'h2);
    press(1'b1, 1'b0);
    check("g1.r2.phase1", 8'(inputPhase), 8'h1);
    check("g1.r2.data1", 8'(data), 8'h1);
    press(1'b0, 1'b1);
    check("g1.lose", 8'(lose), 8'h1);
    check("g1.losePhase", 8'(inputPhase), 8'h0);
    check("g1.loseData", 8'(data), 8'h0);
    check("g1.loseWin", 8'(win), 8'h0);

    // Game 2: 95->2A (10); button held from show into input phase
    startGame();
    check("g2.level", 8'(level), 8'h1);
    check("g2.loseCleared", 8'(lose), 8'h0);
    buttonOn = 1'b1;
    runShow(1, 8'b0000_0010, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("g2.held%0d.phase", i), 8'(inputPhase), 8'h1);
      check($sformatf("g2.held%0d.lose", i), 8'(lose), 8'h0);
      tick;
    end
    buttonOn = 1'b0;
    tick;
    press(1'b0, 1'b0);
    check("g2.noVerdictLose", 8'(lose), 8'h1);

    // Game 3: 2A->54 (00), 54->A9 (01), A9->53 (11), 53->A7 (11)
    startGame();
    playRound(1, 8'b0000_0000, 1'b0);
    playRound(2, 8'b0000_0100, 1'b1);
    playRound(3, 8'b0011_0100, 1'b0);
    playRound(4, 8'b1111_0100, 1'b0);
    check("g3.win", 8'(win), 8'h1);
    check("g3.level", 8'(level), 8'h4);
    check("g3.winLose", 8'(lose), 8'h0);
    check("g3.winPhase", 8'(inputPhase), 8'h0);
    tick;
    tick;
    check("g3.winSticky", 8'(win), 8'h1);

    // Game 4: A7->4E (10), 4E->9D (01), 9D->3B (11); reset mid-show at L=3
    startGame();
    playRound(1, 8'b0000_0010, 1'b0);
    playRound(2, 8'b0000_0110, 1'b0);
    check("g4.level3", 8'(level), 8'h3);
    waitShow();
    check("g4.show0", 8'(show), 8'h2);
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checkAllZero("midShowReset");
    tick;
    tick;
    check("idle.level", 8'(level), 8'h0);
    check("idle.valid", 8'(showValid), 8'h0);

`ifndef PATTERN_STAGE_FREESEED_EN
    // Reset reseeds: first symbol repeats 10
    startGame();
    check("reseed.level", 8'(level), 8'h1);
    runShow(1, 8'b0000_0010, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
